// File: rtl/secuenciador_monitoreo.sv
// rtl/secuenciador_monitoreo.sv - sensor sampling sequencer with fan hysteresis and minimum-hold alarm
module secuenciador_monitoreo #(
  parameter int unsigned PERIODO_MUESTREO = 1000,
  parameter int unsigned T_ALARMA_MIN     = 500,
  parameter logic [4:0]  UMBRAL_ALTO      = 5'd28,
  parameter logic [4:0]  UMBRAL_BAJO      = 5'd24,
  parameter logic [4:0]  TEMP_PELIGRO     = 5'd30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Dato_listo,
  input  logic [4:0] Temperatura,
  input  logic       Presencia,
  input  logic       Ignicion,
  output logic [1:0] Estados,
  output logic       Ventilacion,
  output logic       Alarma,
  output logic       Muestra_valida,
  output logic [4:0] Temp_registrada
);

  typedef enum logic [1:0] {
    ST_ESPERA  = 2'b00,
    ST_LEER    = 2'b01,
    ST_DECIDIR = 2'b10,
    ST_ALERTA  = 2'b11
  } estado_t;

  // Terminal counts of the shared counter; the counter starts at 0 on every state entry.
  localparam logic [15:0] L_TC_PERIODO = 16'(PERIODO_MUESTREO - 1);
  localparam logic [15:0] L_TC_ALARMA  = 16'(T_ALARMA_MIN - 1);

  estado_t     r_estado;
  logic [15:0] r_cnt;
  logic [4:0]  r_temp;
  logic        r_pres;
  logic        r_ign;
  logic        r_vent;
  logic        r_alarma;
  logic        r_mv;

  logic w_fin_periodo;
  logic w_fin_alarma;
  logic w_temp_alta;
  logic w_temp_baja;
  logic w_peligro;
  logic w_vent_sig;

  assign w_fin_periodo = (r_cnt == L_TC_PERIODO);
  assign w_fin_alarma  = (r_cnt == L_TC_ALARMA);

  // Decision terms only ever look at the values latched in LEER, never the live sensors.
  assign w_temp_alta = (r_temp >= UMBRAL_ALTO);
  assign w_temp_baja = (r_temp <= UMBRAL_BAJO);
  assign w_peligro   = (r_temp >= TEMP_PELIGRO) & r_pres & ~r_ign;

  // Fan hysteresis: set wins over clear; between the thresholds the fan keeps its last state.
  assign w_vent_sig = (w_temp_alta & r_pres)   ? 1'b1 :
                      (w_temp_baja | ~r_pres)  ? 1'b0 :
                      r_vent;

  // Sequencer FSM with all outputs registered; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= ST_ESPERA;
      r_cnt    <= '0;
      r_temp   <= '0;
      r_pres   <= 1'b0;
      r_ign    <= 1'b0;
      r_vent   <= 1'b0;
      r_alarma <= 1'b0;
      r_mv     <= 1'b0;
    end else begin
      r_mv <= 1'b0;
      case (r_estado)
        ST_ESPERA: begin
          // A pending request and the periodic terminal count collapse into one sample.
          if (Dato_listo || w_fin_periodo) begin
            r_estado <= ST_LEER;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_LEER: begin
          r_temp   <= Temperatura;
          r_pres   <= Presencia;
          r_ign    <= Ignicion;
          r_cnt    <= '0;
          r_estado <= ST_DECIDIR;
        end
        ST_DECIDIR: begin
          r_vent   <= w_vent_sig;
          r_alarma <= w_peligro;
          r_mv     <= 1'b1;
          r_cnt    <= '0;
          r_estado <= w_peligro ? ST_ALERTA : ST_ESPERA;
        end
        ST_ALERTA: begin
          // Alarm and fan are pinned on for the whole hold; Dato_listo is not looked at here.
          r_alarma <= 1'b1;
          r_vent   <= 1'b1;
          if (w_fin_alarma) begin
            r_estado <= ST_LEER;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_estado <= ST_ESPERA;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  assign Estados         = r_estado;
  assign Ventilacion     = r_vent;
  assign Alarma          = r_alarma;
  assign Muestra_valida  = r_mv;
  assign Temp_registrada = r_temp;

endmodule

// File: tb/tb_secuenciador_monitoreo.sv
// tb/tb_secuenciador_monitoreo.sv - randomized self-checking bench with behavioural reference model
module tb_secuenciador_monitoreo;

  localparam int PER = 8;
  localparam int ALM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Dato_listo = 1'b0;
  logic [4:0] Temperatura = 5'd0;
  logic       Presencia = 1'b0;
  logic       Ignicion = 1'b0;
  logic [1:0] Estados;
  logic       Ventilacion;
  logic       Alarma;
  logic       Muestra_valida;
  logic [4:0] Temp_registrada;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase code, cycles left before the phase times out, and expected outputs.
  int m_est   = 0;
  int m_left  = PER;
  int m_temp  = 0;
  bit m_pres  = 0;
  bit m_ign   = 0;
  bit m_vent  = 0;
  bit m_alarm = 0;
  bit m_mv    = 0;
  bit m_ok    = 0;
  bit danger;

  always #5 clk = ~clk;

  secuenciador_monitoreo #(
    .PERIODO_MUESTREO(PER),
    .T_ALARMA_MIN(ALM),
    .UMBRAL_ALTO(5'd28),
    .UMBRAL_BAJO(5'd24),
    .TEMP_PELIGRO(5'd30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Dato_listo(Dato_listo),
    .Temperatura(Temperatura),
    .Presencia(Presencia),
    .Ignicion(Ignicion),
    .Estados(Estados),
    .Ventilacion(Ventilacion),
    .Alarma(Alarma),
    .Muestra_valida(Muestra_valida),
    .Temp_registrada(Temp_registrada)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model advances on each rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    if (rst) begin
      m_est = 0; m_left = PER; m_temp = 0; m_pres = 0; m_ign = 0;
      m_vent = 0; m_alarm = 0; m_mv = 0; m_ok = 1;
    end else if (m_ok) begin
      m_mv = 0;
      case (m_est)
        0: begin
          if (Dato_listo || m_left == 1) m_est = 1;
          else m_left = m_left - 1;
        end
        1: begin
          m_temp = Temperatura; m_pres = Presencia; m_ign = Ignicion; m_est = 2;
        end
        2: begin
          if (m_temp >= 28 && m_pres) m_vent = 1;
          else if (m_temp <= 24 || !m_pres) m_vent = 0;
          danger = (m_temp >= 30) && m_pres && !m_ign;
          m_alarm = danger;
          m_mv = 1;
          m_est  = danger ? 3 : 0;
          m_left = danger ? ALM : PER;
        end
        default: begin
          m_vent = 1;
          if (m_left == 1) m_est = 1;
          else m_left = m_left - 1;
        end
      endcase
    end
  end

  // Compare every output against the model on each falling edge once reset has been seen.
  always @(negedge clk) begin
    if (m_ok) begin
      check("estados", Estados, m_est);
      check("ventilacion", Ventilacion, m_vent);
      check("alarma", Alarma, m_alarm);
      check("muestra_valida", Muestra_valida, m_mv);
      check("temp_registrada", Temp_registrada, m_temp);
    end
  end

  task automatic wait_espera();
    int n = 0;
    while (m_est != 0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin n_total++; $display("FAIL wait_espera: timeout after %0d cycles, state %0d", n, m_est); end
  endtask

  task automatic wait_terminal();
    int n = 0;
    while (!(m_est == 0 && m_left == 1) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin n_total++; $display("FAIL wait_terminal: timeout after %0d cycles", n); end
  endtask

  task automatic do_sample(input int t, input bit p, input bit i);
    wait_espera();
    Temperatura = 5'(t); Presencia = p; Ignicion = i; Dato_listo = 1'b1;
    @(negedge clk); Dato_listo = 1'b0;
    check("lat_leer", Estados, 1);
    @(negedge clk);
    check("lat_decidir", Estados, 2);
    @(negedge clk);
    check("lat_muestra", Muestra_valida, 1);
  endtask

  initial begin
    int n;
    int cnt_mv;
    int cnt_dec;

    // 1: reset values and free-running period with idle inputs
    repeat (2) @(negedge clk);
    check("rst_estados", Estados, 0);
    check("rst_alarma", Alarma, 0);
    check("rst_vent", Ventilacion, 0);
    check("rst_temp", Temp_registrada, 0);
    rst = 1'b0;
    n = 0;
    while (Estados !== 2'd1 && n < 50) begin @(negedge clk); n++; end
    check("first_leer_cycles", n, 8);
    n = 0;
    do begin @(negedge clk); n++; end while (Estados !== 2'd1 && n < 50);
    check("period_cycles", n, 10);
    check("idle_vent", Ventilacion, 0);
    check("idle_alarma", Alarma, 0);

    // 2: upper threshold sets the fan, no alarm with ignition on
    do_sample(28, 1, 1);
    check("s2_vent", Ventilacion, 1);
    check("s2_alarma", Alarma, 0);
    check("s2_estados", Estados, 0);

    // 3: hysteresis hold, then lower threshold clears
    do_sample(26, 1, 1);
    check("s3_hold", Ventilacion, 1);
    do_sample(24, 1, 1);
    check("s3_clear", Ventilacion, 0);

    // 4: danger, minimum hold, re-sample with ignition on releases
    do_sample(31, 1, 0);
    check("s4_estados", Estados, 3);
    check("s4_alarma", Alarma, 1);
    check("s4_vent", Ventilacion, 1);
    Ignicion = 1'b1;
    n = 0;
    while (Estados !== 2'd1 && n < 50) begin @(negedge clk); n++; end
    check("s4_hold_cycles", n, 4);
    repeat (2) @(negedge clk);
    check("s4_rel_estados", Estados, 0);
    check("s4_rel_alarma", Alarma, 0);

    // 5: Dato_listo ignored in ALERTA, then reset mid-ALERTA
    do_sample(31, 1, 0);
    Dato_listo = 1'b1;
    @(negedge clk); Dato_listo = 1'b0;
    n = 1;
    while (Estados !== 2'd1 && n < 50) begin @(negedge clk); n++; end
    check("s5_ignored_dl", n, 4);
    repeat (2) @(negedge clk);
    check("s5_realerta", Estados, 3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("s5_rst_alarma", Alarma, 0);
    check("s5_rst_estados", Estados, 0);

    // 6: Dato_listo on the terminal-count cycle yields one sample
    Temperatura = 5'd20; Presencia = 1'b0; Ignicion = 1'b0;
    wait_terminal();
    Dato_listo = 1'b1;
    @(negedge clk); Dato_listo = 1'b0;
    check("s6_leer", Estados, 1);
    cnt_mv = 0; cnt_dec = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (Estados === 2'd2) cnt_dec++;
      if (Muestra_valida === 1'b1) cnt_mv++;
    end
    check("s6_decidir_count", cnt_dec, 1);
    check("s6_mv_count", cnt_mv, 1);

    // Randomized traffic with thresholds densely covered and occasional resets
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      Temperatura = 5'($urandom_range(20, 31));
      Presencia   = ($urandom_range(0, 3) != 0);
      Ignicion    = ($urandom_range(0, 2) == 0);
      Dato_listo  = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0; Dato_listo = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
